// File: rtl/boxhead_soc_keycode_queue_if.sv
// rtl/boxhead_soc_keycode_queue_if.sv - Avalon-MM register bus and keycode stream bundle
interface boxhead_soc_keycode_queue_if #(
  parameter int DATA_WIDTH = 8
);
  logic [1:0]            address;
  logic                  chipselect;
  logic                  write_n;
  logic [31:0]           writedata;
  logic [31:0]           readdata;
  logic                  key_valid;
  logic [DATA_WIDTH-1:0] key_data;
  logic                  key_ready;

  modport master (
    output address, chipselect, write_n, writedata, key_ready,
    input  readdata, key_valid, key_data
  );

  modport slave (
    input  address, chipselect, write_n, writedata, key_ready,
    output readdata, key_valid, key_data
  );
endinterface

// File: rtl/boxhead_soc_keycode_queue.sv
// rtl/boxhead_soc_keycode_queue.sv - keycode FIFO with Avalon-MM slave, held-key register and overflow flag
module boxhead_soc_keycode_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int NUM_KEYS   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  boxhead_soc_keycode_queue_if.slave     bus,
  output logic [NUM_KEYS*DATA_WIDTH-1:0] out_port,
  output logic                           overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int KW = NUM_KEYS * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [KW-1:0]         held_q, held_d;

  logic wr, push_req, ctrl_wr, held_wr;
  logic flush, ovf_clr;
  logic empty, full;
  logic pop, push, drop;
  logic unused_wdata;

  assign wr       = bus.chipselect & ~bus.write_n;
  assign push_req = wr && (bus.address == 2'd0);
  assign ctrl_wr  = wr && (bus.address == 2'd1);
  assign held_wr  = wr && (bus.address == 2'd2);
  assign flush    = ctrl_wr & bus.writedata[1];
  assign ovf_clr  = ctrl_wr & bus.writedata[0];

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A flush discards the queue, so a concurrent pop must not also advance rd_ptr.
  assign pop  = ~empty & bus.key_ready & ~flush;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push = push_req & (~full | pop);
  assign drop = push_req & full & ~pop;

  assign bus.key_valid = ~empty;
  assign bus.key_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign out_port      = held_q;
  assign overflow      = ovf_q;
  assign unused_wdata  = ^bus.writedata;

  // Next-state for pointers, occupancy, sticky overflow and held keys.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    held_d   = held_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    if (held_wr) held_d = bus.writedata[KW-1:0];
  end

  // Control state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      held_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      held_q   <= held_d;
    end
  end

  // Keycode storage; contents are don't-care until count covers them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.writedata[DATA_WIDTH-1:0];
  end

  // Zero-latency register read mux.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0: begin
        bus.readdata[0]    = empty;
        bus.readdata[1]    = full;
        bus.readdata[2]    = ovf_q;
        bus.readdata[15:8] = 8'(count_q);
      end
      2'd2:    bus.readdata[KW-1:0]         = held_q;
      2'd3:    bus.readdata[DATA_WIDTH-1:0] = bus.key_data;
      default: bus.readdata = '0;
    endcase
  end
endmodule

// File: tb/tb_boxhead_soc_keycode_queue.sv
// tb/tb_boxhead_soc_keycode_queue.sv - self-checking bench for boxhead_soc_keycode_queue
module tb_boxhead_soc_keycode_queue;
  logic        clk;
  logic        reset;
  logic [31:0] out_port;
  logic        overflow;

  boxhead_soc_keycode_queue_if #(.DATA_WIDTH(8)) bif ();

  boxhead_soc_keycode_queue #(
    .DATA_WIDTH(8),
    .DEPTH(8),
    .NUM_KEYS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif),
    .out_port(out_port),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        kr;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [31:0] exp_status;
  } vec_t;

  vec_t vq[$];
  int   n_checks;
  int   n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic [1:0] a, input logic [31:0] d, input logic kr,
                     input logic ev, input logic [7:0] ed, input logic [31:0] es);
    vec_t v;
    v.is_wr = w; v.addr = a; v.wdata = d; v.kr = kr;
    v.exp_valid = ev; v.exp_data = ed; v.exp_status = es;
    vq.push_back(v);
  endtask

  task automatic idle_bus();
    bif.chipselect = 1'b0;
    bif.write_n    = 1'b1;
    bif.address    = 2'd0;
    bif.writedata  = 32'h0;
    bif.key_ready  = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    bif.address = a;
    #1;
    d = bif.readdata;
    bif.address = 2'd0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic kr);
    @(negedge clk);
    bif.chipselect = 1'b1;
    bif.write_n    = 1'b0;
    bif.address    = a;
    bif.writedata  = d;
    bif.key_ready  = kr;
    @(posedge clk);
    #1;
    idle_bus();
    #1;
  endtask

  logic [31:0] rd;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_bus();
    reset = 1'b1;

    // test plan 1: two pushes, then drain
    add(1, 2'd0, 32'h1A, 0, 1, 8'h1A, 32'h0000_0100);
    add(1, 2'd0, 32'h04, 0, 1, 8'h1A, 32'h0000_0200);
    add(0, 2'd0, 32'h00, 1, 1, 8'h04, 32'h0000_0100);
    add(0, 2'd0, 32'h00, 1, 0, 8'h00, 32'h0000_0001);
    // fill to DEPTH with 0x10..0x17
    for (int k = 0; k < 8; k++)
      add(1, 2'd0, 32'h10 + k, 0, 1, 8'h10, {16'h0, 8'(k + 1), 8'h00} | ((k == 7) ? 32'h2 : 32'h0));
    // ninth push dropped, overflow set
    add(1, 2'd0, 32'h18, 0, 1, 8'h10, 32'h0000_0806);
    // clear overflow, contents intact
    add(1, 2'd1, 32'h1, 0, 1, 8'h10, 32'h0000_0802);
    // full + pop + push in the same cycle
    add(1, 2'd0, 32'h20, 1, 1, 8'h11, 32'h0000_0802);
    // drain: 0x12..0x17 then 0x20, then empty
    for (int k = 1; k <= 7; k++)
      add(0, 2'd0, 32'h0, 1, 1, (k == 7) ? 8'h20 : 8'(8'h11 + k), {16'h0, 8'(8 - k), 8'h00});
    add(0, 2'd0, 32'h0, 1, 0, 8'h00, 32'h0000_0001);

    // reset state
    #12;
    chk("rst key_valid", {31'h0, bif.key_valid}, 32'h0);
    chk("rst key_data", {24'h0, bif.key_data}, 32'h0);
    chk("rst out_port", out_port, 32'h0);
    chk("rst overflow", {31'h0, overflow}, 32'h0);
    read_reg(2'd0, rd);
    chk("rst status", rd, 32'h0000_0001);
    @(negedge clk);
    reset = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      bif.chipselect = vq[i].is_wr;
      bif.write_n    = ~vq[i].is_wr;
      bif.address    = vq[i].addr;
      bif.writedata  = vq[i].wdata;
      bif.key_ready  = vq[i].kr;
      @(posedge clk);
      #1;
      idle_bus();
      #1;
      chk($sformatf("vec%0d key_valid", i), {31'h0, bif.key_valid}, {31'h0, vq[i].exp_valid});
      chk($sformatf("vec%0d key_data", i), {24'h0, bif.key_data}, {24'h0, vq[i].exp_data});
      read_reg(2'd0, rd);
      chk($sformatf("vec%0d status", i), rd, vq[i].exp_status);
    end

    // held-key register
    @(negedge clk);
    chk("held before write", out_port, 32'h0);
    bus_write(2'd2, 32'h2C1A0407, 0);
    chk("held out_port", out_port, 32'h2C1A0407);
    read_reg(2'd2, rd);
    chk("held readback", rd, 32'h2C1A0407);
    read_reg(2'd0, rd);
    chk("held status", rd, 32'h0000_0001);
    read_reg(2'd1, rd);
    chk("addr1 read", rd, 32'h0);
    read_reg(2'd3, rd);
    chk("addr3 empty", rd, 32'h0);

    // write with chipselect low is ignored
    @(negedge clk);
    bif.write_n = 1'b0; bif.address = 2'd0; bif.writedata = 32'h55;
    @(posedge clk); #1; idle_bus(); #1;
    read_reg(2'd0, rd);
    chk("cs0 ignored", rd, 32'h0000_0001);

    // flush with concurrent key_ready
    bus_write(2'd0, 32'h31, 0);
    bus_write(2'd0, 32'h32, 0);
    bus_write(2'd0, 32'h33, 0);
    read_reg(2'd3, rd);
    chk("peek head", rd, 32'h31);
    read_reg(2'd0, rd);
    chk("pre-flush status", rd, 32'h0000_0300);
    bus_write(2'd1, 32'h2, 1);
    chk("flush key_valid", {31'h0, bif.key_valid}, 32'h0);
    read_reg(2'd0, rd);
    chk("flush status", rd, 32'h0000_0001);
    read_reg(2'd3, rd);
    chk("flush addr3", rd, 32'h0);
    // queue resumes from slot 0 after flush
    bus_write(2'd0, 32'h44, 0);
    chk("post-flush data", {24'h0, bif.key_data}, 32'h44);

    // async reset mid-stream
    bus_write(2'd0, 32'h41, 0);
    bus_write(2'd0, 32'h42, 0);
    read_reg(2'd0, rd);
    chk("pre-reset status", rd, 32'h0000_0300);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("in-reset key_valid", {31'h0, bif.key_valid}, 32'h0);
    chk("in-reset out_port", out_port, 32'h0);
    chk("in-reset overflow", {31'h0, overflow}, 32'h0);
    read_reg(2'd0, rd);
    chk("in-reset status", rd, 32'h0000_0001);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    read_reg(2'd0, rd);
    chk("post-reset status", rd, 32'h0000_0001);
    chk("post-reset key_valid", {31'h0, bif.key_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/boxhead_soc_keycode_queue.md
Name: boxhead_soc_keycode_queue

Overview:
- Parametrised successor to the single-register keycode PIO: an Avalon-MM slave that the NIOS writes keyboard keycodes into.
- Keycodes are held in a FIFO and drained by game logic through a valid/ready stream.
- A packed multi-key "held keys" register is exported alongside, for simultaneous key presses.
- Sits between the NIOS-side USB keyboard driver and the player-control FSM.

Parameters:
- DATA_WIDTH, 8, bits per keycode.
- DEPTH, 8, FIFO entries. Power of two, 2..128.
- NUM_KEYS, 4, held-key slots. NUM_KEYS*DATA_WIDTH <= 32.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, zero-latency (combinational from address and state).
- key_valid  out  1  FIFO head valid.
- key_data  out  DATA_WIDTH  FIFO head keycode.
- key_ready  in  1  consumer accepts head.
- out_port  out  NUM_KEYS*DATA_WIDTH  held-key register, slot 0 in the LSBs.
- overflow  out  1  sticky overflow flag.

Behaviour:
- Reset (async, while reset=1): FIFO empty, rd/wr pointers 0, count 0, out_port 0, overflow 0, key_valid 0, key_data 0.
- wr = chipselect & ~write_n.
- Register map:
  - addr 0 write: push writedata[DATA_WIDTH-1:0].
  - addr 0 read: status. [0]=empty, [1]=full, [2]=overflow, [15:8]=count, other bits 0.
  - addr 1 write: writedata[0]=1 clears overflow; writedata[1]=1 flushes the FIFO.
  - addr 1 read: 0.
  - addr 2 write/read: held-key register. Write latches writedata[NUM_KEYS*DATA_WIDTH-1:0]; read returns it zero-extended.
  - addr 3 read: head keycode zero-extended, non-destructive peek; 0 when empty. addr 3 write: ignored.
- Pop: key_valid & key_ready at the rising edge. rd_ptr advances, count decrements.
- Push (addr 0 write):
  - Accepted if count < DEPTH, or if a pop occurs in the same cycle (full + pop + push -> count stays DEPTH, both happen).
  - If full with no pop: data dropped and overflow set to 1 at that edge.
- Latency: a pushed entry is visible on key_valid/key_data the cycle after the write edge. There is no bypass; an empty FIFO never pops in the same cycle as it is pushed.
- key_valid = (count != 0). key_data = mem[rd_ptr], stable while key_valid=1 and key_ready=0.
- Push and pop in the same cycle with 0 < count < DEPTH: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Count is clog2(DEPTH)+1 bits.
- Flush (addr 1, bit1):
  - Pointers and count go to 0 at that edge.
  - A concurrent pop is ignored. A push cannot coincide, since it targets a different address.
  - overflow is unaffected unless bit0 is also set.
- Overflow set and clear in the same cycle is impossible: they target different addresses. Clear via addr 1 bit0 = 1.
- Writes with chipselect=0 are ignored. readdata is valid regardless of chipselect; the fabric qualifies it.
- out_port updates the cycle after an addr 2 write.
- Reset asserted mid-operation: all state is cleared immediately. Entries in flight are lost; this is not an error.

Test Plan:
- Reset, then push 0x1A, 0x04 to addr 0 with key_ready=0:
  - key_valid=1 the cycle after the first write; key_data=0x1A.
  - status read = 0x0000_0200.
  - Assert key_ready for 2 cycles: 0x1A then 0x04 popped; key_valid=0; status=0x0000_0001.
- Push 8 entries 0x10..0x17, key_ready=0:
  - status=0x0000_0802.
  - 9th push 0x18: dropped, overflow=1, status=0x0000_0806.
  - Write addr 1 = 0x1: overflow=0, FIFO contents unchanged, head=0x10.
- FIFO full, assert key_ready and push 0x20 in the same cycle:
  - count stays 8, head becomes 0x11, overflow stays 0.
  - Draining yields 0x11..0x17 then 0x20.
- Write addr 2 = 0x2C1A0407:
  - out_port=0x2C1A0407 the next cycle; addr 2 reads back the same value.
  - Other addresses unaffected.
- 3 entries queued, write addr 1 = 0x2 while key_ready=1:
  - count=0, key_valid=0 the next cycle, no pop observed.
  - addr 3 reads 0.
- Push 2 entries, assert reset mid-stream for 1 cycle:
  - key_valid, out_port, overflow and count are 0 during reset.
  - After release, status=0x0000_0001.
